// File: rtl/bip_dmem_arbiter.sv
// BIP data RAM arbiter: CPU (C) and debug/loader (D) share one RAM port.
// Round-robin per cycle, debug lock with timeout yield to the CPU.
module bip_dmem_arbiter #(
  parameter int NB_DATA      = 16,
  parameter int NB_ADDR      = 10,
  parameter int LOCK_TIMEOUT = 64,
  parameter int NB_CNT       = 7
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_c_req,
  input  logic               i_c_we,
  input  logic [NB_ADDR-1:0] i_c_addr,
  input  logic [NB_DATA-1:0] i_c_wdata,
  output logic               o_c_gnt,
  output logic               o_c_stall,
  output logic               o_c_rvalid,
  output logic [NB_DATA-1:0] o_c_rdata,
  input  logic               i_d_req,
  input  logic               i_d_we,
  input  logic [NB_ADDR-1:0] i_d_addr,
  input  logic [NB_DATA-1:0] i_d_wdata,
  input  logic               i_d_lock,
  output logic               o_d_gnt,
  output logic               o_d_rvalid,
  output logic [NB_DATA-1:0] o_d_rdata,
  output logic               o_locked,
  output logic               o_ram_en,
  output logic               o_ram_we,
  output logic [NB_ADDR-1:0] o_ram_addr,
  output logic [NB_DATA-1:0] o_ram_wdata,
  input  logic [NB_DATA-1:0] i_ram_rdata
);

  typedef enum logic {
    ARB,
    LOCKED
  } state_t;

  state_t            state;
  logic              rr_last;
  logic [NB_CNT-1:0] wait_cnt;
  logic              pend;
  logic              pend_d;
  logic              timeout;
  logic              c_gnt;
  logic              d_gnt;

  // Grant decision: round-robin in ARB, debug-only in LOCKED
  // except when the CPU has waited out the timeout.
  always_comb begin
    timeout = (wait_cnt == NB_CNT'(LOCK_TIMEOUT));
    c_gnt   = 1'b0;
    d_gnt   = 1'b0;
    if (!i_reset) begin
      if (state == LOCKED) begin
        c_gnt = i_c_req & timeout;
        d_gnt = i_d_req & ~timeout;
      end else begin
        c_gnt = i_c_req & (~i_d_req | rr_last);
        d_gnt = i_d_req & (~i_c_req | ~rr_last);
      end
    end
  end

  // RAM port mux from the single winner; idle drives zeros.
  always_comb begin
    o_ram_we    = 1'b0;
    o_ram_addr  = '0;
    o_ram_wdata = '0;
    unique case (1'b1)
      c_gnt: begin
        o_ram_we    = i_c_we;
        o_ram_addr  = i_c_addr;
        o_ram_wdata = i_c_wdata;
      end
      d_gnt: begin
        o_ram_we    = i_d_we;
        o_ram_addr  = i_d_addr;
        o_ram_wdata = i_d_wdata;
      end
      default: ;
    endcase
  end

  assign o_ram_en   = c_gnt | d_gnt;
  assign o_c_gnt    = c_gnt;
  assign o_d_gnt    = d_gnt;
  assign o_c_stall  = i_c_req & ~c_gnt & ~i_reset;
  assign o_locked   = (state == LOCKED) & ~i_reset;
  assign o_c_rvalid = pend & ~pend_d & ~i_reset;
  assign o_d_rvalid = pend & pend_d & ~i_reset;
  assign o_c_rdata  = o_c_rvalid ? i_ram_rdata : '0;
  assign o_d_rdata  = o_d_rvalid ? i_ram_rdata : '0;

  // FSM, round-robin pointer, lock wait counter and read-return tag.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state    <= ARB;
      rr_last  <= 1'b1;
      wait_cnt <= '0;
      pend     <= 1'b0;
      pend_d   <= 1'b0;
    end else begin
      pend   <= (c_gnt | d_gnt) & ~o_ram_we;
      pend_d <= d_gnt;
      case (state)
        ARB: begin
          wait_cnt <= '0;
          if (c_gnt | d_gnt) rr_last <= d_gnt;
          if (i_d_lock) state <= LOCKED;
        end
        LOCKED: begin
          if (!i_d_lock) begin
            state    <= ARB;
            wait_cnt <= '0;
          end else if (timeout || !i_c_req) begin
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + NB_CNT'(1);
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_bip_dmem_arbiter.sv
// Bench for bip_dmem_arbiter: directed scenarios plus random traffic
// checked every cycle against a behavioural model with a shadow RAM.
module tb_bip_dmem_arbiter;
  localparam int NB_DATA = 16;
  localparam int NB_ADDR = 10;
  localparam int TO      = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               c_req = 0, c_we = 0, d_req = 0, d_we = 0, d_lock = 0;
  logic [NB_ADDR-1:0] c_addr = '0, d_addr = '0;
  logic [NB_DATA-1:0] c_wdata = '0, d_wdata = '0;
  logic               c_gnt, c_stall, c_rvalid, d_gnt, d_rvalid, locked;
  logic [NB_DATA-1:0] c_rdata, d_rdata;
  logic               ram_en, ram_we;
  logic [NB_ADDR-1:0] ram_addr;
  logic [NB_DATA-1:0] ram_wdata;
  logic [NB_DATA-1:0] ram_q = '0;
  logic [NB_DATA-1:0] ram [1024];
  logic [NB_DATA-1:0] shadow [1024];

  int total = 0;
  int bad   = 0;

  bit               m_locked = 0;
  bit               m_last_d = 1;
  int               m_wait   = 0;
  bit               m_pv     = 0;
  bit               m_pd     = 0;
  logic [NB_DATA-1:0] m_pdata = '0;

  always #5 clk = ~clk;

  bip_dmem_arbiter #(
    .NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR),
    .LOCK_TIMEOUT(TO), .NB_CNT(7)
  ) dut (
    .i_clock(clk), .i_reset(rst),
    .i_c_req(c_req), .i_c_we(c_we), .i_c_addr(c_addr),
    .i_c_wdata(c_wdata), .o_c_gnt(c_gnt), .o_c_stall(c_stall),
    .o_c_rvalid(c_rvalid), .o_c_rdata(c_rdata),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr),
    .i_d_wdata(d_wdata), .i_d_lock(d_lock), .o_d_gnt(d_gnt),
    .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata), .o_locked(locked),
    .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_addr(ram_addr),
    .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_q)
  );

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_q <= ram[ram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle compare against the model, then advance the model.
  always @(negedge clk) begin : cmp
    int                 win;
    logic               we_e;
    logic [NB_ADDR-1:0] a_e;
    logic [NB_DATA-1:0] wd_e;
    bit                 cv, dv;
    win = 0;
    if (!rst) begin
      if (m_locked) begin
        if (m_wait == TO) win = c_req ? 1 : 0;
        else              win = d_req ? 2 : 0;
      end else if (c_req && d_req) win = m_last_d ? 1 : 2;
      else if (c_req) win = 1;
      else if (d_req) win = 2;
    end
    we_e = (win == 1) ? c_we    : (win == 2) ? d_we    : 1'b0;
    a_e  = (win == 1) ? c_addr  : (win == 2) ? d_addr  : '0;
    wd_e = (win == 1) ? c_wdata : (win == 2) ? d_wdata : '0;
    cv   = !rst && m_pv && !m_pd;
    dv   = !rst && m_pv && m_pd;
    chk("c_gnt", 32'(c_gnt), 32'(win == 1));
    chk("d_gnt", 32'(d_gnt), 32'(win == 2));
    chk("c_stall", 32'(c_stall), 32'(!rst && c_req && win != 1));
    chk("ram_en", 32'(ram_en), 32'(win != 0));
    chk("ram_we", 32'(ram_we), 32'(we_e));
    chk("ram_addr", 32'(ram_addr), 32'(a_e));
    chk("ram_wdata", 32'(ram_wdata), 32'(wd_e));
    chk("c_rvalid", 32'(c_rvalid), 32'(cv));
    chk("d_rvalid", 32'(d_rvalid), 32'(dv));
    chk("c_rdata", 32'(c_rdata), cv ? 32'(m_pdata) : 32'd0);
    chk("d_rdata", 32'(d_rdata), dv ? 32'(m_pdata) : 32'd0);
    chk("locked", 32'(locked), 32'(!rst && m_locked));
    if (rst) begin
      m_locked = 0; m_last_d = 1; m_wait = 0; m_pv = 0; m_pd = 0;
    end else begin
      m_pv = (win != 0) && !we_e;
      m_pd = (win == 2);
      if (m_pv) m_pdata = shadow[a_e];
      if (win != 0 && we_e) shadow[a_e] = wd_e;
      if (!m_locked) begin
        if (win != 0) m_last_d = (win == 2);
        m_wait   = 0;
        m_locked = d_lock;
      end else if (!d_lock) begin
        m_locked = 0;
        m_wait   = 0;
      end else if (m_wait == TO || !c_req) begin
        m_wait = 0;
      end else begin
        m_wait++;
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i]    = 16'(i * 257) ^ 16'h5a5a;
      shadow[i] = ram[i];
    end
    ram[5]    = 16'h1234;
    shadow[5] = 16'h1234;
    c_req = 1; d_req = 1; d_lock = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'({c_gnt, d_gnt, ram_en}), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);

    // C read of word 5 alone
    cyc();
    rst = 0; d_req = 0; d_lock = 0;
    c_req = 1; c_we = 0; c_addr = 10'd5;
    @(negedge clk);
    chk("t1_gnt", 32'(c_gnt), 32'd1);
    chk("t1_addr", 32'(ram_addr), 32'd5);
    chk("t1_we", 32'(ram_we), 32'd0);
    cyc();
    c_req = 0;
    @(negedge clk);
    chk("t1_rvalid", 32'(c_rvalid), 32'd1);
    chk("t1_rdata", 32'(c_rdata), 32'h1234);
    chk("t1_drvalid", 32'(d_rvalid), 32'd0);

    // Conflict right after reset alternates C,D,C,D
    cyc(); rst = 1;
    cyc(); rst = 0;
    c_req = 1; c_addr = 10'd1; d_req = 1; d_we = 0; d_addr = 10'd2;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t2_cgnt", 32'(c_gnt), 32'(k % 2 == 0));
      chk("t2_dgnt", 32'(d_gnt), 32'(k % 2 == 1));
      if (k > 0) chk("t2_crv", 32'(c_rvalid), 32'(k % 2 == 1));
      cyc();
    end
    c_req = 0; d_req = 0;
    @(negedge clk);
    chk("t2_drv", 32'(d_rvalid), 32'd1);

    // D write to the top word then read it back
    cyc();
    d_req = 1; d_we = 1; d_addr = 10'h3ff; d_wdata = 16'hbeef;
    @(negedge clk);
    chk("t4_en", 32'(ram_en), 32'd1);
    chk("t4_we", 32'(ram_we), 32'd1);
    chk("t4_addr", 32'(ram_addr), 32'h3ff);
    chk("t4_wdata", 32'(ram_wdata), 32'hbeef);
    cyc();
    d_we = 0;
    @(negedge clk);
    chk("t4_norv", 32'({c_rvalid, d_rvalid}), 32'd0);
    cyc();
    d_req = 0;
    @(negedge clk);
    chk("t4_rv", 32'(d_rvalid), 32'd1);
    chk("t4_rd", 32'(d_rdata), 32'hbeef);

    // Lock with timeout yield, then unlock at wait_cnt==2
    cyc(); rst = 1;
    cyc(); rst = 0;
    c_req = 1; c_we = 0; c_addr = 10'd3;
    d_req = 1; d_we = 0; d_addr = 10'd4; d_lock = 1;
    @(negedge clk);
    chk("t3_arb_c", 32'(c_gnt), 32'd1);
    chk("t3_arb_unl", 32'(locked), 32'd0);
    for (int k = 0; k < 10; k++) begin
      cyc();
      @(negedge clk);
      chk("t3_cgnt", 32'(c_gnt), 32'(k == 4 || k == 9));
      chk("t3_dgnt", 32'(d_gnt), 32'(!(k == 4 || k == 9)));
      chk("t3_locked", 32'(locked), 32'd1);
    end
    cyc(); @(negedge clk);
    chk("t6_w0", 32'(d_gnt), 32'd1);
    cyc(); @(negedge clk);
    chk("t6_w1", 32'(d_gnt), 32'd1);
    cyc(); d_lock = 0;
    @(negedge clk);
    chk("t6_w2", 32'(d_gnt), 32'd1);
    chk("t6_w2lk", 32'(locked), 32'd1);
    cyc(); @(negedge clk);
    chk("t6_unl", 32'(locked), 32'd0);
    chk("t6_rr_d", 32'(d_gnt), 32'd1);
    cyc(); @(negedge clk);
    chk("t6_rr_c", 32'(c_gnt), 32'd1);
    cyc(); d_lock = 1;
    @(negedge clk);
    chk("t6_arb_d", 32'(d_gnt), 32'd1);
    for (int k = 0; k < 5; k++) begin
      cyc(); @(negedge clk);
      chk("t6_relock", 32'(c_gnt), 32'(k == 4));
    end

    // Reset right after a granted C read drops the return
    cyc(); rst = 1; c_req = 0; d_req = 0; d_lock = 0;
    cyc(); rst = 0; c_req = 1; c_addr = 10'd7;
    @(negedge clk);
    chk("t5_gnt", 32'(c_gnt), 32'd1);
    cyc(); rst = 1; c_req = 0;
    @(negedge clk);
    chk("t5_rst_rv", 32'(c_rvalid), 32'd0);
    cyc(); rst = 0; c_req = 1; d_req = 1;
    @(negedge clk);
    chk("t5_rv", 32'(c_rvalid), 32'd0);
    chk("t5_lk", 32'(locked), 32'd0);
    chk("t5_c", 32'(c_gnt), 32'd1);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      cyc();
      rst     = ($urandom_range(0, 199) == 0);
      c_req   = ($urandom_range(0, 3) != 0);
      c_we    = $urandom_range(0, 1) == 1;
      c_addr  = 10'($urandom_range(0, 15));
      c_wdata = 16'($urandom);
      d_req   = ($urandom_range(0, 3) != 0);
      d_we    = $urandom_range(0, 1) == 1;
      d_addr  = 10'($urandom_range(0, 15));
      d_wdata = 16'($urandom);
      if ($urandom_range(0, 19) == 0) d_lock = ~d_lock;
    end
    cyc();
    rst = 0; c_req = 0; d_req = 0; d_lock = 0;
    cyc();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
